// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB pipeline register: write-back selects,
// load funct3 codes and default widths.
package mem_wb_stage_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load-operand extraction: picks the addressed byte/halfword
// out of the aligned read word and sign- or zero-extends it.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [2:0]            Funct3,
    input  logic [1:0]            Offset,
    input  logic [DATA_WIDTH-1:0] RData,
    output logic [DATA_WIDTH-1:0] LoadData
);

    function automatic logic [DATA_WIDTH-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(DATA_WIDTH-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(DATA_WIDTH-16){sgn & h[15]}}, h};
    endfunction

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = RData[7:0];
        case (Offset)
            2'd0:    w_byte = RData[7:0];
            2'd1:    w_byte = RData[15:8];
            2'd2:    w_byte = RData[23:16];
            default: w_byte = RData[31:24];
        endcase
        // Offset[0] is deliberately ignored for halfwords; misalignment is not trapped.
        w_half = Offset[1] ? RData[31:16] : RData[15:0];
    end

    always_comb begin
        LoadData = '0;
        case (Funct3)
            F3_LB:   LoadData = ext8(w_byte, 1'b1);
            F3_LBU:  LoadData = ext8(w_byte, 1'b0);
            F3_LH:   LoadData = ext16(w_half, 1'b1);
            F3_LHU:  LoadData = ext16(w_half, 1'b0);
            F3_LW:   LoadData = RData;
            default: LoadData = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with priority reset > flush > stall > load and a
// qualified register-file write enable that never targets x0.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  In_Valid,
    input  logic                  In_RegWrite,
    input  logic [1:0]            In_WBSel,
    input  logic [REG_ADDR_W-1:0] In_Rd,
    input  logic [2:0]            In_Funct3,
    input  logic [DATA_WIDTH-1:0] In_ALUResult,
    input  logic [DATA_WIDTH-1:0] In_MemRData,
    input  logic [DATA_WIDTH-1:0] In_PCPlus4,
    output logic                  Out_Valid,
    output logic                  Out_RegWrite,
    output logic [1:0]            Out_WBSel,
    output logic [REG_ADDR_W-1:0] Out_Rd,
    output logic [DATA_WIDTH-1:0] Out_ALUResult,
    output logic [DATA_WIDTH-1:0] Out_LoadData,
    output logic [DATA_WIDTH-1:0] Out_PCPlus4
);

    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_regwrite;

    logic                  r_valid_p1;
    logic                  r_regwrite_p1;
    logic [1:0]            r_wbsel_p1;
    logic [REG_ADDR_W-1:0] r_rd_p1;
    logic [DATA_WIDTH-1:0] r_alu_p1;
    logic [DATA_WIDTH-1:0] r_load_p1;
    logic [DATA_WIDTH-1:0] r_pc4_p1;

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .Funct3  (In_Funct3),
        .Offset  (In_ALUResult[1:0]),
        .RData   (In_MemRData),
        .LoadData(w_load_data)
    );

    assign w_regwrite = In_RegWrite & In_Valid & (In_Rd != '0);

    // MEM -> WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_p1    <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_wbsel_p1    <= WB_MEM;
            r_rd_p1       <= '0;
            r_alu_p1      <= '0;
            r_load_p1     <= '0;
            r_pc4_p1      <= '0;
        end else if (Flush) begin
            r_valid_p1    <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_wbsel_p1    <= WB_MEM;
            r_rd_p1       <= '0;
            r_alu_p1      <= '0;
            r_load_p1     <= '0;
            r_pc4_p1      <= '0;
        end else if (!Stall) begin
            r_valid_p1    <= In_Valid;
            r_regwrite_p1 <= w_regwrite;
            r_wbsel_p1    <= In_WBSel;
            r_rd_p1       <= In_Rd;
            r_alu_p1      <= In_ALUResult;
            r_load_p1     <= w_load_data;
            r_pc4_p1      <= In_PCPlus4;
        end
    end

    assign Out_Valid     = r_valid_p1;
    assign Out_RegWrite  = r_regwrite_p1;
    assign Out_WBSel     = r_wbsel_p1;
    assign Out_Rd        = r_rd_p1;
    assign Out_ALUResult = r_alu_p1;
    assign Out_LoadData  = r_load_p1;
    assign Out_PCPlus4   = r_pc4_p1;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM and WB stages of the 5-stage RISC-V datapath.
- Captures the ALU result, PC+4 and the write-back controls, and registers them on each clock.
- Extracts and sign/zero-extends the load operand from the 32-bit data-memory read word before registering it.
- Its outputs drive the write-back 3:1 select (WBSel 00 = load data, 01 = ALU result, 10 = PC+4) and the register-file write port directly.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported; the load extraction is byte-lane specific.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hold the stage contents; asserted by the hazard unit.
- Flush  in  1  replace the incoming entry with a bubble.
- In_Valid  in  1  MEM stage holds a real instruction.
- In_RegWrite  in  1  instruction writes rd.
- In_WBSel  in  2  write-back source select.
- In_Rd  in  REG_ADDR_W  destination register.
- In_Funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- In_ALUResult  in  DATA_WIDTH  ALU result; also the load address.
- In_MemRData  in  DATA_WIDTH  word-aligned data-memory read data.
- In_PCPlus4  in  DATA_WIDTH  return address.
- Out_Valid  out  1  WB stage holds a real instruction.
- Out_RegWrite  out  1  qualified register-file write enable.
- Out_WBSel  out  2  registered select.
- Out_Rd  out  REG_ADDR_W  registered destination register.
- Out_ALUResult  out  DATA_WIDTH  registered ALU result.
- Out_LoadData  out  DATA_WIDTH  registered, extended load data.
- Out_PCPlus4  out  DATA_WIDTH  registered return address.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; takes effect immediately, independent of clk.
  - All outputs go to 0. Out_WBSel = 2'b00, which is harmless because Out_RegWrite = 0.
  - Reset asserted mid-operation discards the held entry.
  - First capture occurs on the first rising edge after rst_n rises.
- Latency: exactly 1 cycle from MEM inputs to WB outputs. No combinational path from any input to any output.
- Priority per rising edge is rst_n > Flush > Stall > load.
  - Flush = 1: bubble. Out_Valid = 0, Out_RegWrite = 0, Out_Rd = 0, Out_WBSel = 00. Data outputs are cleared to 0. Flush wins over a simultaneous Stall.
  - Stall = 1, Flush = 0: every output holds its value, including Out_Valid.
  - Otherwise load from the inputs.
- Out_RegWrite is loaded as In_RegWrite & In_Valid & (In_Rd != 0). This makes x0 writes impossible.
- Out_Valid is loaded from In_Valid. An invalid entry still loads its data, but with RegWrite forced to 0.
- Load extraction (combinational, before the register):
  - Byte offset off = In_ALUResult[1:0].
  - LB / LBU: select byte In_MemRData[8*off+7 : 8*off], then sign-extend (LB) or zero-extend (LBU).
  - LH / LHU: select the halfword given by In_ALUResult[1] (0 = bits 15:0, 1 = bits 31:16), then sign-extend (LH) or zero-extend (LHU). In_ALUResult[0] is ignored; misaligned halfword loads are not trapped.
  - LW: pass In_MemRData unchanged. off is ignored.
  - Undefined funct3 (011, 110, 111): Out_LoadData = 0.
- Extraction is applied every cycle regardless of In_WBSel. A non-load instruction produces don't-care load data that WB does not select.
- Out_ALUResult and Out_PCPlus4 pass through unchanged, with no arithmetic in this block.

Decomposition:
- Shared package holds:
  - WBSel constants: WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - DATA_WIDTH and REG_ADDR_W defaults.
- One natural sub-module, load_align: purely combinational. Inputs are Funct3, Offset[1:0] and RData; output is LoadData. It is instantiated ahead of the register bank.
- mem_wb_stage itself contains only the register bank and the priority logic.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle while the stage holds a valid entry -> all outputs are 0 immediately, without waiting for a clock edge. After release, the first edge loads the inputs.
- Load extraction with In_MemRData = 0x8765_F0A1:
  - LB, off = 0 -> 0xFFFF_FFA1. LBU, off = 0 -> 0x0000_00A1.
  - LB, off = 3 -> 0xFFFF_FF87.
  - LH, off = 2 -> 0xFFFF_8765. LHU, off = 1 -> 0x0000_F0A1.
  - LW -> 0x8765_F0A1.
- Write qualification:
  - In_Rd = 0, In_RegWrite = 1, In_Valid = 1 -> Out_RegWrite = 0 and Out_Valid = 1.
  - In_Rd = 5, In_Valid = 0 -> Out_RegWrite = 0.
- Stall: load an entry with ALUResult 0x0000_1234, then hold Stall = 1 for 3 cycles while the inputs change -> outputs stay at 0x0000_1234. Releasing Stall loads the new inputs on the next edge.
- Flush with simultaneous Stall: a valid entry is held, then Flush = 1 and Stall = 1 -> next edge gives Out_Valid = 0, Out_RegWrite = 0, Out_Rd = 0.
- Pass-through: JAL with In_WBSel = 10 and In_PCPlus4 = 0x0000_0108 -> Out_PCPlus4 = 0x0000_0108 and Out_WBSel = 10, one cycle later.
